// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if
// Memory-bus bundle between the arbiter and the top-level memory port.
//
// Signals:
//   addressOut  memory address, driven by the arbiter
//   valueOut    memory write data, driven by the arbiter
//   loadOut     memory read strobe, driven by the arbiter
//   storeOut    memory write strobe, driven by the arbiter
//   valueIn     memory read data, driven by the memory
//   readyIn     memory acknowledge, driven by the memory
//
// Modports:
//   master  the arbiter side (drives address, data and strobes)
//   slave   the memory side (drives read data and acknowledge)
interface memory_arbiter_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);

  logic [ADDRESS_WIDTH-1:0] addressOut;
  logic [DATA_WIDTH-1:0]    valueOut;
  logic                     loadOut;
  logic                     storeOut;
  logic [DATA_WIDTH-1:0]    valueIn;
  logic                     readyIn;

  modport master (
    output addressOut,
    output valueOut,
    output loadOut,
    output storeOut,
    input  valueIn,
    input  readyIn
  );

  modport slave (
    input  addressOut,
    input  valueOut,
    input  loadOut,
    input  storeOut,
    output valueIn,
    output readyIn
  );

endinterface

// File: rtl/memory_arbiter.sv
// memory_arbiter
// Shares the core's single memory port between the instruction-fetch
// requester and the load/store data requester. Arbitrates round-robin,
// registers the winning request onto the memory bus, holds it until the
// memory acknowledges, returns read data with a one-cycle ready pulse and
// aborts stalled accesses after TIMEOUT_CYCLES busy cycles (0 disables).
//
// Ports:
//   clockIn         sole clock, rising edge
//   resetIn         synchronous active-low reset
//   fetchAddressIn  fetch address
//   fetchLoadIn     fetch read request (level)
//   fetchValueOut   fetch read data (held until next fetch completion)
//   fetchReadyOut   fetch completion pulse
//   dataAddressIn   data address
//   dataValueIn     store data
//   dataLoadIn      data read request (level)
//   dataStoreIn     data write request (level, wins over dataLoadIn)
//   dataValueOut    data read data (held until next data completion)
//   dataReadyOut    data completion pulse
//   bus             memory bus (master side): address, write data,
//                   load/store strobes, read data, acknowledge
//   faultOut        sticky timeout flag, cleared only by reset
module memory_arbiter #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clockIn,
  input  logic                     resetIn,

  input  logic [ADDRESS_WIDTH-1:0] fetchAddressIn,
  input  logic                     fetchLoadIn,
  output logic [DATA_WIDTH-1:0]    fetchValueOut,
  output logic                     fetchReadyOut,

  input  logic [ADDRESS_WIDTH-1:0] dataAddressIn,
  input  logic [DATA_WIDTH-1:0]    dataValueIn,
  input  logic                     dataLoadIn,
  input  logic                     dataStoreIn,
  output logic [DATA_WIDTH-1:0]    dataValueOut,
  output logic                     dataReadyOut,

  memory_arbiter_if.master         bus,

  output logic                     faultOut
);

  // The counter only ever has to reach TIMEOUT_CYCLES-1 before an abort,
  // so it is sized for that value; with the timeout disabled it simply
  // saturates at all-ones.
  localparam int COUNT_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [COUNT_WIDTH-1:0] COUNT_LAST =
    (TIMEOUT_CYCLES > 0) ? COUNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic TIMEOUT_ENABLED = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESPOND
  } stateType;

  stateType state;
  stateType nextState;

  logic                   fetchReq;
  logic                   dataReq;
  logic                   anyReq;
  logic                   grantData;
  logic                   timeoutHit;
  logic                   completeNow;
  logic                   abortNow;

  logic                   winnerData;
  logic                   lastGrantData;
  logic [COUNT_WIDTH-1:0] timeoutCount;

  // Request decode and per-cycle decisions. On a tie the requester that
  // did not win last time gets the bus; lastGrantData resets high so the
  // first tie after reset goes to fetch. A memory acknowledge in the same
  // cycle as the timeout expiry counts as a normal completion.
  always_comb begin
    fetchReq    = fetchLoadIn;
    dataReq     = dataLoadIn | dataStoreIn;
    anyReq      = fetchReq | dataReq;
    grantData   = dataReq & (~fetchReq | ~lastGrantData);
    timeoutHit  = TIMEOUT_ENABLED && (timeoutCount == COUNT_LAST);
    completeNow = (state == BUSY) && bus.readyIn;
    abortNow    = (state == BUSY) && !bus.readyIn && timeoutHit;
  end

  // State register: reset always lands in IDLE, abandoning any pending
  // access without a ready pulse.
  always_ff @(posedge clockIn) begin
    if (!resetIn) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic: IDLE grants as soon as anyone asks, BUSY waits for
  // an acknowledge or abort, RESPOND lasts exactly one cycle and ignores
  // requests so the winner has time to drop its request level.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (anyReq) begin
          nextState = BUSY;
        end
      end
      BUSY: begin
        if (completeNow || abortNow) begin
          nextState = RESPOND;
        end
      end
      RESPOND: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Registered outputs and bookkeeping. Everything the outside world sees
  // comes straight from a flop. The bus is loaded on the grant edge and
  // left untouched during BUSY; only the strobes drop on completion, so
  // address and write data simply hold their last value afterwards. Ready
  // pulses are set on the BUSY->RESPOND edge and cleared on every other
  // edge, which makes them exactly one cycle wide.
  always_ff @(posedge clockIn) begin
    if (!resetIn) begin
      bus.addressOut <= '0;
      bus.valueOut   <= '0;
      bus.loadOut    <= 1'b0;
      bus.storeOut   <= 1'b0;
      fetchValueOut  <= '0;
      fetchReadyOut  <= 1'b0;
      dataValueOut   <= '0;
      dataReadyOut   <= 1'b0;
      faultOut       <= 1'b0;
      winnerData     <= 1'b0;
      lastGrantData  <= 1'b1;
      timeoutCount   <= '0;
    end else begin
      fetchReadyOut <= 1'b0;
      dataReadyOut  <= 1'b0;
      case (state)
        IDLE: begin
          if (anyReq) begin
            winnerData    <= grantData;
            lastGrantData <= grantData;
            timeoutCount  <= '0;
            if (grantData) begin
              bus.addressOut <= dataAddressIn;
              bus.valueOut   <= dataValueIn;
              bus.storeOut   <= dataStoreIn;
              bus.loadOut    <= dataLoadIn & ~dataStoreIn;
            end else begin
              bus.addressOut <= fetchAddressIn;
              bus.valueOut   <= '0;
              bus.storeOut   <= 1'b0;
              bus.loadOut    <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (completeNow || abortNow) begin
            bus.loadOut  <= 1'b0;
            bus.storeOut <= 1'b0;
            if (winnerData) begin
              dataValueOut <= completeNow ? bus.valueIn : '0;
              dataReadyOut <= 1'b1;
            end else begin
              fetchValueOut <= completeNow ? bus.valueIn : '0;
              fetchReadyOut <= 1'b1;
            end
            if (abortNow) begin
              faultOut <= 1'b1;
            end
          end else if (timeoutCount != '1) begin
            timeoutCount <= timeoutCount + COUNT_WIDTH'(1);
          end
        end
        RESPOND: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter
// Directed bench for memory_arbiter with a four-cycle timeout. Inputs are
// driven and outputs sampled on the falling clock edge; the bench itself
// plays the memory by driving the slave side of the bus interface.
module tb_memory_arbiter;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 4;

  logic          clockIn = 1'b0;
  logic          resetIn;
  logic [AW-1:0] fetchAddressIn;
  logic          fetchLoadIn;
  logic [DW-1:0] fetchValueOut;
  logic          fetchReadyOut;
  logic [AW-1:0] dataAddressIn;
  logic [DW-1:0] dataValueIn;
  logic          dataLoadIn;
  logic          dataStoreIn;
  logic [DW-1:0] dataValueOut;
  logic          dataReadyOut;
  logic          faultOut;

  int checkCount = 0;
  int errorCount = 0;

  memory_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  memory_arbiter #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clockIn       (clockIn),
    .resetIn       (resetIn),
    .fetchAddressIn(fetchAddressIn),
    .fetchLoadIn   (fetchLoadIn),
    .fetchValueOut (fetchValueOut),
    .fetchReadyOut (fetchReadyOut),
    .dataAddressIn (dataAddressIn),
    .dataValueIn   (dataValueIn),
    .dataLoadIn    (dataLoadIn),
    .dataStoreIn   (dataStoreIn),
    .dataValueOut  (dataValueOut),
    .dataReadyOut  (dataReadyOut),
    .bus           (bus.master),
    .faultOut      (faultOut)
  );

  always #5 clockIn = ~clockIn;

  // Safety net so the run always ends even if the stimulus stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives every input for the current cycle and advances to the next
  // falling edge, where the resulting outputs can be sampled.
  task automatic applyStimulus(input logic rst, input logic fl, input logic [AW-1:0] fa,
                               input logic dl, input logic ds, input logic [AW-1:0] da,
                               input logic [DW-1:0] dv, input logic rdy,
                               input logic [DW-1:0] rv);
    resetIn        = rst;
    fetchLoadIn    = fl;
    fetchAddressIn = fa;
    dataLoadIn     = dl;
    dataStoreIn    = ds;
    dataAddressIn  = da;
    dataValueIn    = dv;
    bus.readyIn    = rdy;
    bus.valueIn    = rv;
    @(negedge clockIn);
  endtask

  initial begin
    int phase;
    int access;
    logic expectData;

    $display("[TB] starting memory_arbiter bench");

    // Reset held for two edges with random inputs.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'($urandom), $urandom, 1'($urandom), 1'($urandom),
                    $urandom, $urandom, 1'($urandom), $urandom);
    end
    checkOutput("reset.addressOut", bus.addressOut, 0);
    checkOutput("reset.valueOut", bus.valueOut, 0);
    checkOutput("reset.strobes", {bus.loadOut, bus.storeOut}, 0);
    checkOutput("reset.fetchValueOut", fetchValueOut, 0);
    checkOutput("reset.dataValueOut", dataValueOut, 0);
    checkOutput("reset.readies", {fetchReadyOut, dataReadyOut}, 0);
    checkOutput("reset.faultOut", faultOut, 0);

    // Release with no requests: stays idle.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("release.strobes", {bus.loadOut, bus.storeOut}, 0);
      checkOutput("release.readies", {fetchReadyOut, dataReadyOut}, 0);
    end

    // Single fetch, memory acknowledges on the third busy cycle.
    applyStimulus(1'b1, 1, 32'h100, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      checkOutput("fetch.loadOut", bus.loadOut, 1);
      checkOutput("fetch.storeOut", bus.storeOut, 0);
      checkOutput("fetch.addressOut", bus.addressOut, 32'h100);
      checkOutput("fetch.busyReadies", {fetchReadyOut, dataReadyOut}, 0);
      applyStimulus(1'b1, 1, 32'h100, 0, 0, 0, 0, (i == 3),
                    (i == 3) ? 32'hDEADBEEF : 32'h0);
    end
    checkOutput("fetch.strobeDrop", bus.loadOut, 0);
    checkOutput("fetch.fetchReadyOut", fetchReadyOut, 1);
    checkOutput("fetch.dataReadyOut", dataReadyOut, 0);
    checkOutput("fetch.fetchValueOut", fetchValueOut, 32'hDEADBEEF);
    checkOutput("fetch.faultOut", faultOut, 0);
    applyStimulus(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("fetch.pulseEnd", {fetchReadyOut, dataReadyOut}, 0);
    checkOutput("fetch.valueHeld", fetchValueOut, 32'hDEADBEEF);
    checkOutput("fetch.idleStrobe", bus.loadOut, 0);

    // Store and load both asserted: treated as a store.
    applyStimulus(1'b1, 0, 0, 1, 1, 32'h20, 32'h55, 0, 0);
    checkOutput("store.storeOut", bus.storeOut, 1);
    checkOutput("store.loadOut", bus.loadOut, 0);
    checkOutput("store.valueOut", bus.valueOut, 32'h55);
    checkOutput("store.addressOut", bus.addressOut, 32'h20);
    applyStimulus(1'b1, 0, 0, 1, 1, 32'h20, 32'h55, 1, 32'h12345678);
    checkOutput("store.dataReadyOut", dataReadyOut, 1);
    checkOutput("store.fetchReadyOut", fetchReadyOut, 0);
    checkOutput("store.strobeDrop", bus.storeOut, 0);
    applyStimulus(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("store.pulseEnd", dataReadyOut, 0);
    checkOutput("store.fetchValueHeld", fetchValueOut, 32'hDEADBEEF);

    // Contention: both requesters held, memory always ready. Grants go
    // fetch, data, fetch, data at one access per three cycles.
    applyStimulus(1'b1, 1, 32'h200, 1, 0, 32'h300, 32'h77, 1, 32'hA0000000);
    for (int i = 1; i <= 12; i++) begin
      phase      = (i - 1) % 3;
      access     = (i - 1) / 3;
      expectData = (access % 2) == 1;
      if (phase == 0) begin
        checkOutput("contend.loadOut", bus.loadOut, 1);
        checkOutput("contend.addressOut", bus.addressOut,
                    expectData ? 32'h300 : 32'h200);
        checkOutput("contend.busyReadies", {fetchReadyOut, dataReadyOut}, 0);
      end else if (phase == 1) begin
        checkOutput("contend.readies", {fetchReadyOut, dataReadyOut},
                    expectData ? 2'b01 : 2'b10);
        checkOutput("contend.value", expectData ? dataValueOut : fetchValueOut,
                    32'hA0000000 + 32'(i - 1));
        checkOutput("contend.strobeDrop", bus.loadOut, 0);
      end else begin
        checkOutput("contend.idleReadies", {fetchReadyOut, dataReadyOut}, 0);
        checkOutput("contend.idleStrobe", bus.loadOut, 0);
      end
      applyStimulus(1'b1, (i < 12), 32'h200, (i < 12), 0, 32'h300, 32'h77, 1,
                    32'hA0000000 + 32'(i));
    end
    checkOutput("contend.quiet", {bus.loadOut, bus.storeOut}, 0);

    // Acknowledge in the final allowed busy cycle: normal completion.
    applyStimulus(1'b1, 1, 32'h80, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      checkOutput("lateReady.loadOut", bus.loadOut, 1);
      checkOutput("lateReady.faultOut", faultOut, 0);
      applyStimulus(1'b1, 1, 32'h80, 0, 0, 0, 0, (i == 4),
                    (i == 4) ? 32'hCAFEF00D : 32'h0);
    end
    checkOutput("lateReady.fetchReadyOut", fetchReadyOut, 1);
    checkOutput("lateReady.fetchValueOut", fetchValueOut, 32'hCAFEF00D);
    checkOutput("lateReady.faultOut", faultOut, 0);
    checkOutput("lateReady.strobeDrop", bus.loadOut, 0);
    applyStimulus(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("lateReady.faultAfter", faultOut, 0);

    // Timeout: data load never acknowledged.
    applyStimulus(1'b1, 0, 0, 1, 0, 32'h40, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      checkOutput("timeout.loadOut", bus.loadOut, 1);
      checkOutput("timeout.addressOut", bus.addressOut, 32'h40);
      checkOutput("timeout.noReady", dataReadyOut, 0);
      checkOutput("timeout.noFaultYet", faultOut, 0);
      applyStimulus(1'b1, 0, 0, 1, 0, 32'h40, 0, 0, 0);
    end
    checkOutput("timeout.strobeDrop", bus.loadOut, 0);
    checkOutput("timeout.dataReadyOut", dataReadyOut, 1);
    checkOutput("timeout.dataValueOut", dataValueOut, 0);
    checkOutput("timeout.faultOut", faultOut, 1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("timeout.faultSticky", faultOut, 1);
      checkOutput("timeout.pulseEnd", dataReadyOut, 0);
    end

    // Reset in the middle of a fetch with no acknowledge.
    applyStimulus(1'b1, 1, 32'h500, 0, 0, 0, 0, 0, 0);
    checkOutput("midReset.busyLoad", bus.loadOut, 1);
    applyStimulus(1'b1, 1, 32'h500, 0, 0, 0, 0, 0, 0);
    checkOutput("midReset.busyAddress", bus.addressOut, 32'h500);
    applyStimulus(1'b0, 1, 32'h500, 0, 0, 0, 0, 0, 0);
    checkOutput("midReset.strobes", {bus.loadOut, bus.storeOut}, 0);
    checkOutput("midReset.addressOut", bus.addressOut, 0);
    checkOutput("midReset.fetchValueOut", fetchValueOut, 0);
    checkOutput("midReset.dataValueOut", dataValueOut, 0);
    checkOutput("midReset.faultOut", faultOut, 0);
    checkOutput("midReset.readies", {fetchReadyOut, dataReadyOut}, 0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("midReset.noPulse", {fetchReadyOut, dataReadyOut}, 0);
    end

    // Fresh lone data request after reset is granted.
    applyStimulus(1'b1, 0, 0, 1, 0, 32'h600, 0, 0, 0);
    checkOutput("postReset.dataLoad", bus.loadOut, 1);
    checkOutput("postReset.dataAddress", bus.addressOut, 32'h600);
    applyStimulus(1'b1, 0, 0, 1, 0, 32'h600, 0, 1, 32'h0000600D);
    checkOutput("postReset.dataReady", {fetchReadyOut, dataReadyOut}, 2'b01);
    checkOutput("postReset.dataValue", dataValueOut, 32'h0000600D);
    applyStimulus(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Tie after a data grant: fetch must win.
    applyStimulus(1'b1, 1, 32'h700, 1, 0, 32'h800, 0, 0, 0);
    checkOutput("tie.addressOut", bus.addressOut, 32'h700);
    applyStimulus(1'b1, 1, 32'h700, 1, 0, 32'h800, 0, 1, 32'h1111);
    checkOutput("tie.readies", {fetchReadyOut, dataReadyOut}, 2'b10);
    applyStimulus(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
